// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: holds every domain in reset, then releases them one by one in index order.
// Optional saturating soft-reset counter output when RST_SEQ_CNT_EN is defined.
module reset_seq_ctrl #(
   parameter int NUM_DOM = 4,
   parameter int HOLD    = 8,
   parameter int GAP     = 16
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               sw_rst_req,
   output logic               sw_rst_ack,
   output logic [NUM_DOM-1:0] dom_rst_n,
   output logic               seq_done
`ifdef RST_SEQ_CNT_EN
   ,
   output logic [7:0]         soft_rst_cnt
`endif
);

   localparam int CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

   localparam logic [CNT_W-1:0] HOLD_C   = CNT_W'(HOLD);
   localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GAP);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOM - 1);

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_RELEASE,
      ST_RUN
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [IDX_W-1:0]   r_idx;
   logic [NUM_DOM-1:0] r_dom_rst_n;
   logic               r_seq_done;
   logic               r_ack;
   logic               r_req_d;

   state_t             w_state_next;
   logic [CNT_W-1:0]   w_cnt_next;
   logic [IDX_W-1:0]   w_idx_next;
   logic [NUM_DOM-1:0] w_dom_next;
   logic               w_done_next;
   logic               w_ack_next;
   logic               w_release;
   logic               w_accept;

   // r_cnt counts edges since the sequence (re)started or since the last release.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_idx_next   = r_idx;
      w_done_next  = r_seq_done;
      w_ack_next   = 1'b0;
      w_release    = 1'b0;
      w_accept     = 1'b0;

      case (r_state)
         ST_HOLD: begin
            if (r_cnt == HOLD_C) begin
               w_release = 1'b1;
            end else begin
               w_cnt_next = r_cnt + CNT_ONE;
            end
         end
         ST_RELEASE: begin
            if (r_cnt == GAP_C) begin
               w_release = 1'b1;
            end else begin
               w_cnt_next = r_cnt + CNT_ONE;
            end
         end
         ST_RUN: begin
            w_accept = sw_rst_req && !r_req_d;
         end
         default: begin
            w_state_next = ST_HOLD;
         end
      endcase

      if (w_release) begin
         if (r_idx == IDX_LAST) begin
            w_state_next = ST_RUN;
            w_cnt_next   = '0;
            w_idx_next   = '0;
            w_done_next  = 1'b1;
         end else begin
            w_state_next = ST_RELEASE;
            w_cnt_next   = CNT_ONE;
            w_idx_next   = r_idx + IDX_ONE;
         end
      end

      // The acceptance edge itself is edge zero of the new hold window.
      if (w_accept) begin
         w_state_next = ST_HOLD;
         w_cnt_next   = CNT_ONE;
         w_idx_next   = '0;
         w_done_next  = 1'b0;
         w_ack_next   = 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DOM; gi++) begin : g_dom
         assign w_dom_next[gi] = !w_accept &&
                                 (r_dom_rst_n[gi] || (w_release && (r_idx == IDX_W'(gi))));
      end
   endgenerate

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state     <= ST_HOLD;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_dom_rst_n <= '0;
         r_seq_done  <= 1'b0;
         r_ack       <= 1'b0;
         r_req_d     <= 1'b1;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_idx       <= w_idx_next;
         r_dom_rst_n <= w_dom_next;
         r_seq_done  <= w_done_next;
         r_ack       <= w_ack_next;
         r_req_d     <= sw_rst_req;
      end
   end

   assign sw_rst_ack = r_ack;
   assign dom_rst_n  = r_dom_rst_n;
   assign seq_done   = r_seq_done;

`ifdef RST_SEQ_CNT_EN
   logic [7:0] r_soft_cnt;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_soft_cnt <= 8'd0;
      end else if (w_accept && (r_soft_cnt != 8'hFF)) begin
         r_soft_cnt <= r_soft_cnt + 8'd1;
      end
   end

   assign soft_rst_cnt = r_soft_cnt;
`endif

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Bench for reset_seq_ctrl: edge-indexed release-time model checked every cycle,
// plus literal release offsets for the default configuration.
module tb_reset_seq_ctrl;

   localparam int N = 4;
   localparam int H = 8;
   localparam int G = 16;

   logic         sys_clk = 1'b0;
   logic         sys_rst = 1'b1;
   logic         sw_rst_req = 1'b0;
   logic         sw_rst_ack;
   logic [N-1:0] dom_rst_n;
   logic         seq_done;
`ifdef RST_SEQ_CNT_EN
   logic [7:0]   soft_rst_cnt;
`endif

   reset_seq_ctrl #(.NUM_DOM(N), .HOLD(H), .GAP(G)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .sw_rst_req (sw_rst_req),
      .sw_rst_ack (sw_rst_ack),
      .dom_rst_n  (dom_rst_n),
      .seq_done   (seq_done)
`ifdef RST_SEQ_CNT_EN
      ,
      .soft_rst_cnt (soft_rst_cnt)
`endif
   );

   initial forever #5 sys_clk = ~sys_clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: each domain is released a fixed number of edges after the sequence start edge.
   bit         m_valid = 1'b0;
   bit         m_started;
   bit         m_req_d;
   bit         m_acc;
   bit [N-1:0] m_dom;
   bit         m_done;
   bit         m_ack;
   int         m_start;
   int         m_cnt;

   initial forever begin
      @(posedge sys_clk);
      cyc++;
      if (sys_rst) begin
         m_started = 1'b0;
         m_req_d   = 1'b1;
         m_dom     = '0;
         m_done    = 1'b0;
         m_ack     = 1'b0;
         m_cnt     = 0;
      end else begin
         m_acc = m_done && sw_rst_req && !m_req_d;
         if (!m_started) begin
            m_started = 1'b1;
            m_start   = cyc;
         end
         if (m_acc) begin
            m_start = cyc;
            if (m_cnt < 255) m_cnt++;
         end
         for (int k = 0; k < N; k++) begin
            m_dom[k] = !m_acc && (cyc >= m_start + H + k * G);
         end
         m_done  = m_dom[N-1];
         m_ack   = m_acc;
         m_req_d = sw_rst_req;
      end
      m_valid = 1'b1;
   end

   int         rise [N];
   int         done_rise;
   int         ack_cnt;
   logic [N-1:0] prev_dom = '0;
   logic       prev_done = 1'b0;

   initial forever begin
      @(negedge sys_clk);
      if (m_valid) begin
         chk("cyc_dom_rst_n", dom_rst_n, m_dom);
         chk("cyc_seq_done", seq_done, m_done);
         chk("cyc_sw_rst_ack", sw_rst_ack, m_ack);
`ifdef RST_SEQ_CNT_EN
         chk("cyc_soft_rst_cnt", soft_rst_cnt, m_cnt);
`endif
         for (int k = 0; k < N; k++) begin
            if (dom_rst_n[k] === 1'b1 && prev_dom[k] !== 1'b1) rise[k] = cyc;
         end
         if (seq_done === 1'b1 && prev_done !== 1'b1) done_rise = cyc;
         if (sw_rst_ack === 1'b1) ack_cnt++;
         prev_dom  = dom_rst_n;
         prev_done = seq_done;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic clear_rec();
      for (int k = 0; k < N; k++) rise[k] = -1000;
      done_rise = -1000;
      ack_cnt   = 0;
   endtask

   task automatic check_rises(input string tag, input int base);
      int offs [N];
      offs = '{8, 24, 40, 56};
      for (int k = 0; k < N; k++) begin
         chk($sformatf("%s_rise%0d", tag, k), rise[k] - base, offs[k]);
      end
      chk($sformatf("%s_done_rise", tag), done_rise - base, 56);
   endtask

   int e0;
   int s0;

   initial begin
      // Boot with the request held high all the way into RUN.
      sys_rst = 1'b1;
      sw_rst_req = 1'b1;
      tick(3);
      chk("reset_dom", dom_rst_n, 4'b0000);
      chk("reset_done", seq_done, 1'b0);
      chk("reset_ack", sw_rst_ack, 1'b0);
      clear_rec();
      sys_rst = 1'b0;
      e0 = cyc + 1;
      tick(70);
      $display("TXN boot e0=%0d rises=%0d,%0d,%0d,%0d", e0, rise[0], rise[1], rise[2], rise[3]);
      check_rises("boot", e0);
      chk("held_req_no_ack", ack_cnt, 0);

      // Drop and re-raise: accepted soft reset.
      sw_rst_req = 1'b0;
      tick(1);
      clear_rec();
      sw_rst_req = 1'b1;
      s0 = cyc + 1;
      tick(1);
      chk("s0_ack", sw_rst_ack, 1'b1);
      chk("s0_dom", dom_rst_n, 4'b0000);
      chk("s0_done", seq_done, 1'b0);
      tick(1);
      chk("ack_one_cycle", sw_rst_ack, 1'b0);
      sw_rst_req = 1'b0;
      tick(68);
      $display("TXN soft s0=%0d rise0=%0d acks=%0d", s0, rise[0], ack_cnt);
      check_rises("soft", s0);
      chk("soft_ack_count", ack_cnt, 1);

      // Request toggles during RELEASE are ignored.
      sys_rst = 1'b1;
      tick(2);
      clear_rec();
      sys_rst = 1'b0;
      e0 = cyc + 1;
      tick(30);
      sw_rst_req = 1'b1;
      tick(3);
      sw_rst_req = 1'b0;
      tick(2);
      sw_rst_req = 1'b1;
      tick(2);
      sw_rst_req = 1'b0;
      tick(33);
      $display("TXN ignore e0=%0d acks=%0d", e0, ack_cnt);
      check_rises("ignore", e0);
      chk("ignore_ack_count", ack_cnt, 0);

      // One-cycle sys_rst mid-RELEASE restarts the sequence.
      sys_rst = 1'b1;
      tick(2);
      sys_rst = 1'b0;
      e0 = cyc + 1;
      tick(30);
      chk("mid_release_dom", dom_rst_n, 4'b0011);
      sys_rst = 1'b1;
      tick(1);
      chk("restart_dom", dom_rst_n, 4'b0000);
      chk("restart_done", seq_done, 1'b0);
      clear_rec();
      sys_rst = 1'b0;
      e0 = cyc + 1;
      tick(70);
      $display("TXN restart e0=%0d rise3=%0d", e0, rise[3]);
      check_rises("restart", e0);

      // sys_rst coincident with a would-be accepted soft reset.
      sw_rst_req = 1'b1;
      sys_rst = 1'b1;
      tick(1);
      chk("coinc_ack", sw_rst_ack, 1'b0);
      chk("coinc_dom", dom_rst_n, 4'b0000);
      chk("coinc_done", seq_done, 1'b0);
      clear_rec();
      sys_rst = 1'b0;
      e0 = cyc + 1;
      tick(70);
      $display("TXN coincident e0=%0d acks=%0d", e0, ack_cnt);
      check_rises("coinc", e0);
      chk("coinc_ack_count", ack_cnt, 0);

`ifdef RST_SEQ_CNT_EN
      // 300 soft resets saturate the counter at 255.
      for (int i = 0; i < 300; i++) begin
         sw_rst_req = 1'b0;
         tick(1);
         sw_rst_req = 1'b1;
         tick(1);
         tick(57);
      end
      $display("TXN soft_cnt after 300 = %0d", soft_rst_cnt);
      chk("soft_cnt_sat", soft_rst_cnt, 8'd255);
      sys_rst = 1'b1;
      tick(1);
      chk("soft_cnt_clear", soft_rst_cnt, 8'd0);
      sys_rst = 1'b0;
      tick(2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
